// File: rtl/tte_tx_sched.sv
// Time-aware transmit scheduler: moves whole TT/BE frames from the source pointer/data FIFOs into the MAC-side queue.
// TT frames start only inside the TT window. BE frames start outside it, and only when they end before the window opens.
module tte_tx_sched #(
    parameter int unsigned CLK_NS   = 5,
    parameter int unsigned MAX_LEN  = 1518,
    parameter int unsigned OVH_NS   = 960,
    parameter int unsigned DQ_DEPTH = 4096
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        cfg_en,
    input  logic [31:0] cfg_cycle_ns,
    input  logic [31:0] cfg_tt_start,
    input  logic [31:0] cfg_tt_len,
    input  logic [1:0]  speed,
    output logic        tptr_fifo_rd,
    input  logic [15:0] tptr_fifo_din,
    input  logic        tptr_fifo_empty,
    output logic        tdata_fifo_rd,
    input  logic [7:0]  tdata_fifo_din,
    output logic        ptr_fifo_rd,
    input  logic [15:0] ptr_fifo_din,
    input  logic        ptr_fifo_empty,
    output logic        data_fifo_rd,
    input  logic [7:0]  data_fifo_din,
    output logic        o_data_wr,
    output logic [7:0]  o_data_dout,
    output logic        o_ptr_wr,
    output logic [15:0] o_ptr_dout,
    input  logic        o_ptr_full,
    input  logic [11:0] o_data_depth,
    output logic [31:0] phase_ns,
    output logic        tt_open,
    output logic [15:0] drop_cnt
);
    typedef enum logic [1:0] {IDLE, XFER, WPTR, DROP} state_t;

    state_t           state_q;
    logic [31:0]      phase_q, phase_d, need;
    logic [32:0]      ph_sum, win_end, t2w;
    logic [9:0]       byte_ns;
    logic [1:0]       pf_rd_q, pf_cap_q, vld_q, clr, pf_empty, ill, space;
    logic [1:0][10:0] len_q, pf_din;
    logic             be_fits, go, go_tt, go_drop, fin;
    logic [10:0]      sel_len, cnt_q;
    logic             sel_tt_q, drd_q, owr_q, pwr_q;
    logic [15:0]      pdout_q, drop_q;
    logic             unused_hi;

    assign unused_hi = ^{tptr_fifo_din[15:11], ptr_fifo_din[15:11]};

    // Wrap subtracts the cycle length instead of zeroing so a non-multiple cycle does not drift.
    always_comb begin
        ph_sum  = {1'b0, phase_q} + 33'(CLK_NS);
        phase_d = (ph_sum >= {1'b0, cfg_cycle_ns}) ? 32'(ph_sum - {1'b0, cfg_cycle_ns}) : ph_sum[31:0];
        win_end = {1'b0, cfg_tt_start} + {1'b0, cfg_tt_len};
        t2w     = (phase_q < cfg_tt_start) ? {1'b0, cfg_tt_start - phase_q}
                                           : {1'b0, cfg_cycle_ns} - {1'b0, phase_q} + {1'b0, cfg_tt_start};
    end

    assign tt_open  = cfg_en & (phase_q >= cfg_tt_start) & ({1'b0, phase_q} < win_end);
    assign phase_ns = phase_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) phase_q <= '0;
        else       phase_q <= phase_d;
    end

    always_comb begin
        case (speed)
            2'b00:   byte_ns = 10'd800;
            2'b01:   byte_ns = 10'd80;
            default: byte_ns = 10'd8;
        endcase
    end

    // Index 1 is the TT queue, index 0 the BE queue.
    assign pf_empty     = {tptr_fifo_empty, ptr_fifo_empty};
    assign pf_din[1]    = tptr_fifo_din[10:0];
    assign pf_din[0]    = ptr_fifo_din[10:0];
    assign tptr_fifo_rd = pf_rd_q[1];
    assign ptr_fifo_rd  = pf_rd_q[0];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pf_rd_q  <= '0;
            pf_cap_q <= '0;
            vld_q    <= '0;
            len_q    <= '0;
        end else begin
            for (int q = 0; q < 2; q++) begin
                pf_cap_q[q] <= pf_rd_q[q];
                pf_rd_q[q]  <= !vld_q[q] && !pf_cap_q[q] && !pf_rd_q[q] && !pf_empty[q];
                if (pf_cap_q[q]) begin
                    vld_q[q] <= 1'b1;
                    len_q[q] <= pf_din[q];
                end else if (clr[q]) begin
                    vld_q[q] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        for (int q = 0; q < 2; q++) begin
            ill[q]   = (len_q[q] == 11'd0) || (32'(len_q[q]) > MAX_LEN);
            space[q] = !o_ptr_full && ((32'(o_data_depth) + 32'(len_q[q])) <= DQ_DEPTH);
        end
        need    = 32'(len_q[0]) * 32'(byte_ns) + OVH_NS;
        be_fits = !cfg_en || (!tt_open && (t2w >= {1'b0, need}));
    end

    // First match wins; a BE frame that does not fit simply stays in its prefetch slot.
    always_comb begin
        go      = 1'b0;
        go_tt   = 1'b0;
        go_drop = 1'b0;
        if (vld_q[1] && ill[1]) begin
            go = 1'b1; go_tt = 1'b1; go_drop = 1'b1;
        end else if (vld_q[1] && (tt_open || !cfg_en) && space[1]) begin
            go = 1'b1; go_tt = 1'b1;
        end else if (vld_q[0] && ill[0]) begin
            go = 1'b1; go_drop = 1'b1;
        end else if (vld_q[0] && be_fits && space[0]) begin
            go = 1'b1;
        end
        sel_len = go_tt ? len_q[1] : len_q[0];
    end

    assign fin = (state_q == WPTR) || ((state_q == DROP) && !drd_q);
    assign clr = {fin && sel_tt_q, fin && !sel_tt_q};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            sel_tt_q <= 1'b0;
            cnt_q    <= '0;
            drd_q    <= 1'b0;
            owr_q    <= 1'b0;
            pwr_q    <= 1'b0;
            pdout_q  <= '0;
            drop_q   <= '0;
        end else begin
            owr_q <= drd_q && (state_q == XFER);
            case (state_q)
                IDLE: begin
                    if (go) begin
                        sel_tt_q <= go_tt;
                        cnt_q    <= sel_len - 11'd1;
                        drd_q    <= (sel_len != 11'd0);
                        pdout_q  <= {go_tt, 4'b0000, sel_len};
                        state_q  <= go_drop ? DROP : XFER;
                    end
                end
                XFER, DROP: begin
                    // One idle cycle after the last read lets the final byte land before closing the frame.
                    if (drd_q) begin
                        if (cnt_q == 11'd0) drd_q <= 1'b0;
                        else                cnt_q <= cnt_q - 11'd1;
                    end else if (state_q == XFER) begin
                        pwr_q   <= 1'b1;
                        state_q <= WPTR;
                    end else begin
                        if (drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
                        state_q <= IDLE;
                    end
                end
                WPTR: begin
                    pwr_q   <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tdata_fifo_rd = drd_q && sel_tt_q;
    assign data_fifo_rd  = drd_q && !sel_tt_q;
    assign o_data_wr     = owr_q;
    assign o_data_dout   = owr_q ? (sel_tt_q ? tdata_fifo_din : data_fifo_din) : 8'h00;
    assign o_ptr_wr      = pwr_q;
    assign o_ptr_dout    = pdout_q;
    assign drop_cnt      = drop_q;

endmodule

// File: tb/tb_tte_tx_sched.sv
// Bench for tte_tx_sched: queue-based source FIFOs, a MAC-side monitor and per-scenario checks
// against frame/phase expectations computed from the scheduling rules.
module tb_tte_tx_sched;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        cfg_en;
    logic [31:0] cfg_cycle_ns, cfg_tt_start, cfg_tt_len;
    logic [1:0]  speed;
    logic        tptr_fifo_rd, tdata_fifo_rd, ptr_fifo_rd, data_fifo_rd;
    logic [15:0] tptr_fifo_din, ptr_fifo_din;
    logic        tptr_fifo_empty, ptr_fifo_empty;
    logic [7:0]  tdata_fifo_din, data_fifo_din;
    logic        o_data_wr, o_ptr_wr, o_ptr_full, tt_open;
    logic [7:0]  o_data_dout;
    logic [15:0] o_ptr_dout, drop_cnt;
    logic [11:0] o_data_depth;
    logic [31:0] phase_ns;

    int checks = 0;
    int failures = 0;

    logic [15:0] tptr_q[$], bptr_q[$];
    logic [7:0]  tdat_q[$], bdat_q[$];
    int          underflow;

    int          exp_len_t[$], exp_len_b[$];
    logic [7:0]  exp_byt_t[$], exp_byt_b[$];

    logic [15:0] mon_ptr[$];
    int          mon_first[$], mon_ptrcyc[$], mon_len[$];
    logic [31:0] mon_phase[$];
    logic [7:0]  mon_bytes[$];
    int          mon_nwr, cur_n, first_c, cyc;
    logic [31:0] first_ph;

    always #5 clk = ~clk;

    tte_tx_sched dut (
        .clk(clk), .rstn(rstn), .cfg_en(cfg_en), .cfg_cycle_ns(cfg_cycle_ns),
        .cfg_tt_start(cfg_tt_start), .cfg_tt_len(cfg_tt_len), .speed(speed),
        .tptr_fifo_rd(tptr_fifo_rd), .tptr_fifo_din(tptr_fifo_din), .tptr_fifo_empty(tptr_fifo_empty),
        .tdata_fifo_rd(tdata_fifo_rd), .tdata_fifo_din(tdata_fifo_din),
        .ptr_fifo_rd(ptr_fifo_rd), .ptr_fifo_din(ptr_fifo_din), .ptr_fifo_empty(ptr_fifo_empty),
        .data_fifo_rd(data_fifo_rd), .data_fifo_din(data_fifo_din),
        .o_data_wr(o_data_wr), .o_data_dout(o_data_dout), .o_ptr_wr(o_ptr_wr), .o_ptr_dout(o_ptr_dout),
        .o_ptr_full(o_ptr_full), .o_data_depth(o_data_depth),
        .phase_ns(phase_ns), .tt_open(tt_open), .drop_cnt(drop_cnt)
    );

    // Source FIFOs: registered read data, valid the cycle after rd; cleared by the shared reset.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tptr_q.delete(); bptr_q.delete(); tdat_q.delete(); bdat_q.delete();
            tptr_fifo_din <= '0; ptr_fifo_din <= '0; tdata_fifo_din <= '0; data_fifo_din <= '0;
            tptr_fifo_empty <= 1'b1; ptr_fifo_empty <= 1'b1;
        end else begin
            if (tptr_fifo_rd) begin
                if (tptr_q.size() > 0) tptr_fifo_din <= tptr_q.pop_front(); else underflow++;
            end
            if (ptr_fifo_rd) begin
                if (bptr_q.size() > 0) ptr_fifo_din <= bptr_q.pop_front(); else underflow++;
            end
            if (tdata_fifo_rd) begin
                if (tdat_q.size() > 0) tdata_fifo_din <= tdat_q.pop_front(); else underflow++;
            end
            if (data_fifo_rd) begin
                if (bdat_q.size() > 0) data_fifo_din <= bdat_q.pop_front(); else underflow++;
            end
            tptr_fifo_empty <= (tptr_q.size() == 0);
            ptr_fifo_empty  <= (bptr_q.size() == 0);
        end
    end

    always @(posedge clk or negedge rstn) begin
        if (!rstn) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (rstn) begin
            if (o_data_wr) begin
                if (cur_n == 0) begin
                    first_c  = cyc;
                    first_ph = phase_ns;
                end
                mon_bytes.push_back(o_data_dout);
                cur_n++;
                mon_nwr++;
            end
            if (o_ptr_wr) begin
                mon_ptr.push_back(o_ptr_dout);
                mon_first.push_back(first_c);
                mon_phase.push_back(first_ph);
                mon_len.push_back(cur_n);
                mon_ptrcyc.push_back(cyc);
                cur_n = 0;
            end
        end
    end

    function automatic logic [31:0] exp_phase(input int c, input logic [31:0] cy);
        longint unsigned t;
        t = longint'(c) * 5;
        return 32'(t % longint'(cy));
    endfunction

    task automatic do_reset(input bit en, input logic [31:0] cy, input logic [31:0] st,
                            input logic [31:0] ln, input logic [1:0] spd);
        @(negedge clk);
        rstn = 1'b0;
        cfg_en = en; cfg_cycle_ns = cy; cfg_tt_start = st; cfg_tt_len = ln; speed = spd;
        o_ptr_full = 1'b0; o_data_depth = '0;
        repeat (3) @(negedge clk);
        mon_ptr.delete(); mon_first.delete(); mon_ptrcyc.delete(); mon_len.delete();
        mon_phase.delete(); mon_bytes.delete();
        exp_len_t.delete(); exp_len_b.delete(); exp_byt_t.delete(); exp_byt_b.delete();
        mon_nwr = 0; cur_n = 0; underflow = 0;
        rstn = 1'b1;
    endtask

    // Random junk in ptr bits [15:11]; only [10:0] carries the length.
    task automatic push_frame(input bit tt, input int len, input int nb);
        logic [7:0]  b;
        logic [15:0] p;
        bit          legal;
        legal = (len >= 1) && (len <= 1518);
        p = {5'($urandom), 11'(len)};
        if (tt) tptr_q.push_back(p); else bptr_q.push_back(p);
        for (int i = 0; i < nb; i++) begin
            b = 8'($urandom);
            if (tt) tdat_q.push_back(b); else bdat_q.push_back(b);
            if (legal) begin
                if (tt) exp_byt_t.push_back(b); else exp_byt_b.push_back(b);
            end
        end
        if (legal) begin
            if (tt) exp_len_t.push_back(len); else exp_len_b.push_back(len);
        end
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic wait_frames(input int n, input int budget);
        for (int i = 0; i < budget && mon_ptr.size() < n; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rstn = 1'b0;
        cfg_en = 1'b0; cfg_cycle_ns = 32'd100000; cfg_tt_start = 32'd0; cfg_tt_len = 32'd0; speed = 2'b10;
        o_ptr_full = 1'b0; o_data_depth = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({o_data_wr, o_ptr_wr, tptr_fifo_rd, ptr_fifo_rd, tdata_fifo_rd, data_fifo_rd, tt_open} !== 7'b0) begin
            failures++;
            $display("FAIL reset_strobes got %b want 0000000", {o_data_wr, o_ptr_wr, tptr_fifo_rd, ptr_fifo_rd, tdata_fifo_rd, data_fifo_rd, tt_open});
        end
        checks++;
        if ({o_ptr_dout, o_data_dout} !== 24'h0) begin
            failures++; $display("FAIL reset_dout got %h want 0", {o_ptr_dout, o_data_dout});
        end
        checks++;
        if (phase_ns !== 32'd0) begin failures++; $display("FAIL reset_phase got %0d want 0", phase_ns); end
        checks++;
        if (drop_cnt !== 16'd0) begin failures++; $display("FAIL reset_drop got %0d want 0", drop_cnt); end
    endtask

    task automatic test_tt_first();
        int k;
        do_reset(1'b0, 32'd100000, 32'd0, 32'd0, 2'b10);
        push_frame(1'b0, 60, 60);
        push_frame(1'b1, 60, 60);
        wait_frames(2, 1000);
        repeat (5) @(negedge clk);
        checks++;
        if (mon_ptr.size() != 2) begin
            failures++; $display("FAIL prio_nframes got %0d want 2", mon_ptr.size());
        end else begin
            checks++;
            if (mon_ptr[0] !== 16'h803C) begin failures++; $display("FAIL prio_ptr0 got %h want 803c", mon_ptr[0]); end
            checks++;
            if (mon_ptr[1] !== 16'h003C) begin failures++; $display("FAIL prio_ptr1 got %h want 003c", mon_ptr[1]); end
            checks++;
            if (mon_ptrcyc[0] - mon_first[0] != 60) begin
                failures++; $display("FAIL prio_ptr_latency got %0d want 60", mon_ptrcyc[0] - mon_first[0]);
            end
        end
        checks++;
        if (mon_nwr != 120) begin failures++; $display("FAIL prio_nwr got %0d want 120", mon_nwr); end
        k = 0;
        for (int i = 0; i < 120 && i < mon_bytes.size(); i++) begin
            if (mon_bytes[i] !== ((i < 60) ? exp_byt_t[i] : exp_byt_b[i - 60])) k++;
        end
        checks++;
        if (k != 0) begin failures++; $display("FAIL prio_bytes got %0d bad bytes want 0", k); end
    endtask

    task automatic test_window();
        do_reset(1'b1, 32'd100000, 32'd50000, 32'd10000, 2'b01);
        push_frame(1'b1, 300, 300);
        push_frame(1'b0, 1514, 1514);
        wait_cyc(9999);
        checks++;
        if (phase_ns !== exp_phase(cyc, 32'd100000) || tt_open !== 1'b0 || mon_nwr != 0) begin
            failures++; $display("FAIL win_before got ph=%0d open=%b nwr=%0d want ph=%0d open=0 nwr=0", phase_ns, tt_open, mon_nwr, exp_phase(cyc, 32'd100000));
        end
        wait_cyc(10000);
        checks++;
        if (tt_open !== 1'b1) begin failures++; $display("FAIL win_open got %b want 1", tt_open); end
        wait_cyc(11999);
        checks++;
        if (tt_open !== 1'b1) begin failures++; $display("FAIL win_last got %b want 1", tt_open); end
        wait_cyc(12000);
        checks++;
        if (tt_open !== 1'b0) begin failures++; $display("FAIL win_close got %b want 0", tt_open); end
        wait_cyc(20100);
        checks++;
        if (phase_ns !== exp_phase(cyc, 32'd100000)) begin
            failures++; $display("FAIL win_wrap_phase got %0d want %0d", phase_ns, exp_phase(cyc, 32'd100000));
        end
        checks++;
        if (mon_ptr.size() != 1) begin
            failures++; $display("FAIL win_nframes got %0d want 1", mon_ptr.size());
        end else begin
            checks++;
            if (mon_ptr[0] !== 16'h812C || mon_phase[0] < 32'd50000 || mon_phase[0] > 32'd50015) begin
                failures++; $display("FAIL win_tt got ptr=%h ph=%0d want ptr=812c ph in [50000,50015]", mon_ptr[0], mon_phase[0]);
            end
        end
        checks++;
        if (mon_nwr != 300 || bdat_q.size() != 1514) begin
            failures++; $display("FAIL win_be_held got nwr=%0d bq=%0d want 300 1514", mon_nwr, bdat_q.size());
        end
    endtask

    task automatic test_guard();
        do_reset(1'b1, 32'd100000, 32'd50000, 32'd10000, 2'b01);
        wait_cyc(8000);
        push_frame(1'b0, 100, 100);
        wait_cyc(8200);
        checks++;
        if (mon_ptr.size() != 1) begin
            failures++; $display("FAIL guard_fit got %0d frames want 1", mon_ptr.size());
        end else begin
            checks++;
            if (mon_ptr[0] !== 16'h0064 || mon_phase[0] < 32'd40000 || mon_phase[0] > 32'd40050) begin
                failures++; $display("FAIL guard_fit_ph got ptr=%h ph=%0d want 0064 ph in [40000,40050]", mon_ptr[0], mon_phase[0]);
            end
        end
        wait_cyc(9000);
        push_frame(1'b0, 100, 100);
        wait_cyc(11999);
        checks++;
        if (mon_ptr.size() != 1) begin failures++; $display("FAIL guard_hold got %0d frames want 1", mon_ptr.size()); end
        wait_cyc(12200);
        checks++;
        if (mon_ptr.size() != 2) begin
            failures++; $display("FAIL guard_late got %0d frames want 2", mon_ptr.size());
        end else begin
            checks++;
            if (mon_phase[1] < 32'd60000 || mon_phase[1] > 32'd60015) begin
                failures++; $display("FAIL guard_late_ph got %0d want [60000,60015]", mon_phase[1]);
            end
        end
    endtask

    task automatic test_drop();
        int k;
        do_reset(1'b0, 32'd100000, 32'd0, 32'd0, 2'($urandom_range(0, 3)));
        push_frame(1'b0, 0, 0);
        push_frame(1'b0, 1600, 1600);
        push_frame(1'b0, 60, 60);
        wait_frames(1, 5000);
        repeat (10) @(negedge clk);
        checks++;
        if (mon_ptr.size() != 1 || mon_ptr[0] !== 16'h003C) begin
            failures++; $display("FAIL drop_frames got n=%0d ptr0=%h want n=1 ptr=003c", mon_ptr.size(), (mon_ptr.size() > 0) ? mon_ptr[0] : 16'hxxxx);
        end
        checks++;
        if (drop_cnt !== 16'd2) begin failures++; $display("FAIL drop_cnt got %0d want 2", drop_cnt); end
        checks++;
        if (bdat_q.size() != 0 || mon_nwr != 60) begin
            failures++; $display("FAIL drop_consume got left=%0d nwr=%0d want 0 60", bdat_q.size(), mon_nwr);
        end
        k = 0;
        for (int i = 0; i < 60 && i < mon_bytes.size(); i++) if (mon_bytes[i] !== exp_byt_b[i]) k++;
        checks++;
        if (k != 0) begin failures++; $display("FAIL drop_next_bytes got %0d bad want 0", k); end
    endtask

    task automatic test_space_wrap();
        do_reset(1'b0, 32'd99999, 32'd0, 32'd0, 2'b10);
        o_data_depth = 12'd4080;
        push_frame(1'b0, 60, 60);
        repeat (50) @(negedge clk);
        o_data_depth = 12'd4037;
        repeat (30) @(negedge clk);
        checks++;
        if (mon_nwr != 0) begin failures++; $display("FAIL space_block got nwr=%0d want 0", mon_nwr); end
        o_data_depth = 12'd4036;
        wait_frames(1, 200);
        checks++;
        if (mon_ptr.size() != 1 || mon_nwr != 60) begin
            failures++; $display("FAIL space_go got n=%0d nwr=%0d want 1 60", mon_ptr.size(), mon_nwr);
        end
        wait_cyc(19999);
        checks++;
        if (phase_ns !== 32'd99995) begin failures++; $display("FAIL wrap_pre got %0d want 99995", phase_ns); end
        wait_cyc(20000);
        checks++;
        if (phase_ns !== exp_phase(cyc, 32'd99999)) begin
            failures++; $display("FAIL wrap_post got %0d want %0d", phase_ns, exp_phase(cyc, 32'd99999));
        end
    endtask

    task automatic test_random();
        int ndrop, total, sumlen, cls, r, len, el, bad;
        logic [7:0] eb;
        do_reset(1'b0, 32'd100000, 32'd0, 32'd0, 2'($urandom_range(0, 3)));
        ndrop = 0; sumlen = 0;
        for (int i = 0; i < 14; i++) begin
            cls = $urandom_range(0, 1);
            r = $urandom_range(0, 9);
            len = (r == 0) ? 0 : (r == 1) ? 1519 + $urandom_range(0, 80) : $urandom_range(1, 120);
            if (len == 0 || len > 1518) ndrop++; else sumlen += len;
            push_frame(cls[0], len, len);
        end
        total = exp_len_t.size() + exp_len_b.size();
        wait_frames(total, 20000);
        repeat (20) @(negedge clk);
        checks++;
        if (mon_ptr.size() != total) begin failures++; $display("FAIL rnd_nframes got %0d want %0d", mon_ptr.size(), total); end
        for (int f = 0; f < mon_ptr.size(); f++) begin
            if (mon_ptr[f][15]) begin
                el = (exp_len_t.size() > 0) ? exp_len_t.pop_front() : -1;
            end else begin
                el = (exp_len_b.size() > 0) ? exp_len_b.pop_front() : -1;
            end
            checks++;
            if (el < 0 || mon_ptr[f] !== {mon_ptr[f][15], 4'b0000, 11'(el)} || mon_len[f] != el || mon_ptrcyc[f] - mon_first[f] != el) begin
                failures++; $display("FAIL rnd_frame%0d got ptr=%h n=%0d lat=%0d want len=%0d", f, mon_ptr[f], mon_len[f], mon_ptrcyc[f] - mon_first[f], el);
            end
            bad = 0;
            for (int k = 0; k < mon_len[f]; k++) begin
                if (mon_ptr[f][15]) eb = (exp_byt_t.size() > 0) ? exp_byt_t.pop_front() : 8'hxx;
                else                eb = (exp_byt_b.size() > 0) ? exp_byt_b.pop_front() : 8'hxx;
                if (mon_bytes.size() == 0 || mon_bytes.pop_front() !== eb) bad++;
            end
            checks++;
            if (bad != 0) begin failures++; $display("FAIL rnd_bytes%0d got %0d bad want 0", f, bad); end
        end
        checks++;
        if (drop_cnt !== 16'(ndrop)) begin failures++; $display("FAIL rnd_drop got %0d want %0d", drop_cnt, ndrop); end
        checks++;
        if (mon_nwr != sumlen || underflow != 0 || tdat_q.size() != 0 || bdat_q.size() != 0) begin
            failures++; $display("FAIL rnd_totals got nwr=%0d uf=%0d tq=%0d bq=%0d want %0d 0 0 0", mon_nwr, underflow, tdat_q.size(), bdat_q.size(), sumlen);
        end
    endtask

    task automatic test_reset_midframe();
        do_reset(1'b0, 32'd100000, 32'd0, 32'd0, 2'b10);
        push_frame(1'b0, 200, 200);
        for (int i = 0; i < 500 && mon_nwr < 20; i++) @(negedge clk);
        checks++;
        if (mon_nwr < 20) begin failures++; $display("FAIL midrst_start got nwr=%0d want >=20", mon_nwr); end
        rstn = 1'b0;
        @(negedge clk);
        checks++;
        if ({o_data_wr, o_ptr_wr, data_fifo_rd} !== 3'b000) begin
            failures++; $display("FAIL midrst_idle got %b want 000", {o_data_wr, o_ptr_wr, data_fifo_rd});
        end
        rstn = 1'b1;
        repeat (300) @(negedge clk);
        checks++;
        if (mon_ptr.size() != 0) begin failures++; $display("FAIL midrst_noptr got %0d want 0", mon_ptr.size()); end
    endtask

    initial begin
        underflow = 0; mon_nwr = 0; cur_n = 0; first_c = 0; first_ph = '0;
        test_reset();
        test_tt_first();
        test_drop();
        test_random();
        test_reset_midframe();
        test_guard();
        test_window();
        test_space_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
